// File: rtl/axi_mem_slave.sv
// rtl/axi_mem_slave.sv - AXI4 memory responder with independent write and read burst engines
// INCR/FIXED bursts into a word-addressed array; DECERR past the array, SLVERR on protocol errors.
module axi_mem_slave #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int MEM_DEPTH      = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [AXI_ID_WIDTH-1:0]       S_AXI_AWID,
  input  logic [7:0]                    S_AXI_AWLEN,
  input  logic [2:0]                    S_AXI_AWSIZE,
  input  logic [1:0]                    S_AXI_AWBURST,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                          S_AXI_WLAST,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [AXI_ID_WIDTH-1:0]       S_AXI_BID,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [AXI_ID_WIDTH-1:0]       S_AXI_ARID,
  input  logic [7:0]                    S_AXI_ARLEN,
  input  logic [2:0]                    S_AXI_ARSIZE,
  input  logic [1:0]                    S_AXI_ARBURST,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [AXI_ID_WIDTH-1:0]       S_AXI_RID,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RLAST,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY
);
  localparam int BYTES = AXI_DATA_WIDTH / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [2:0] BEAT_SIZE = 3'(LSB);
  localparam logic [AXI_ADDR_WIDTH-1:0] STEP = AXI_ADDR_WIDTH'(BYTES);
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  function automatic logic in_range(input logic [AXI_ADDR_WIDTH-1:0] a);
    return (a >> (LSB + IDX_W)) == '0;
  endfunction

  w_state_t                  w_state;
  logic [AXI_ADDR_WIDTH-1:0] w_addr;
  logic [AXI_ID_WIDTH-1:0]   w_id;
  logic [7:0]                w_len, w_cnt;
  logic [1:0]                w_burst;
  logic                      w_slverr, w_decerr;
  logic                      awready, wready, bvalid;
  logic [AXI_ID_WIDTH-1:0]   bid;
  logic [1:0]                bresp;

  logic w_fire, w_last_beat, w_ok, w_slverr_nxt, w_decerr_nxt;
  logic [IDX_W-1:0] w_idx;
  assign w_fire       = S_AXI_WVALID && wready;
  assign w_last_beat  = (w_cnt == w_len);
  assign w_ok         = in_range(w_addr);
  assign w_idx        = w_addr[LSB +: IDX_W];
  assign w_slverr_nxt = w_slverr || (S_AXI_WLAST != w_last_beat);
  assign w_decerr_nxt = w_decerr || !w_ok;

  // Out-of-range beats are dropped; reset cancels a beat presented on the reset edge.
  always_ff @(posedge clk) begin
    if (rst_n && w_fire && w_ok) begin
      for (int b = 0; b < BYTES; b++)
        if (S_AXI_WSTRB[b]) mem[w_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state  <= W_IDLE;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bid      <= '0;
      bresp    <= RESP_OKAY;
      w_addr   <= '0;
      w_id     <= '0;
      w_len    <= '0;
      w_cnt    <= '0;
      w_burst  <= '0;
      w_slverr <= 1'b0;
      w_decerr <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          awready <= 1'b1;
          if (S_AXI_AWVALID && awready) begin
            w_addr   <= S_AXI_AWADDR;
            w_id     <= S_AXI_AWID;
            w_len    <= S_AXI_AWLEN;
            w_burst  <= S_AXI_AWBURST;
            w_cnt    <= '0;
            w_slverr <= S_AXI_AWBURST[1] || (S_AXI_AWSIZE != BEAT_SIZE);
            w_decerr <= 1'b0;
            awready  <= 1'b0;
            wready   <= 1'b1;
            w_state  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_cnt    <= w_cnt + 8'd1;
            w_slverr <= w_slverr_nxt;
            w_decerr <= w_decerr_nxt;
            if (w_burst != BURST_FIXED) w_addr <= w_addr + STEP;
            if (w_last_beat) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bid     <= w_id;
              bresp   <= w_decerr_nxt ? RESP_DECERR : (w_slverr_nxt ? RESP_SLVERR : RESP_OKAY);
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid  <= 1'b0;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  r_state_t                  r_state;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [7:0]                r_len, r_cnt;
  logic [1:0]                r_burst;
  logic                      r_slverr;
  logic                      arready, rvalid;
  logic                      r_ok;

  assign r_ok = in_range(r_addr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= R_IDLE;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      r_addr   <= '0;
      r_id     <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_burst  <= '0;
      r_slverr <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (S_AXI_ARVALID && arready) begin
            r_addr   <= S_AXI_ARADDR;
            r_id     <= S_AXI_ARID;
            r_len    <= S_AXI_ARLEN;
            r_burst  <= S_AXI_ARBURST;
            r_cnt    <= '0;
            r_slverr <= S_AXI_ARBURST[1] || (S_AXI_ARSIZE != BEAT_SIZE);
            arready  <= 1'b0;
            rvalid   <= 1'b1;
            r_state  <= R_DATA;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            r_cnt <= r_cnt + 8'd1;
            if (r_burst != BURST_FIXED) r_addr <= r_addr + STEP;
            if (r_cnt == r_len) begin
              rvalid  <= 1'b0;
              r_state <= R_IDLE;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Read beat fields derive from latched state, so they hold while stalled and see same-cycle-old writes.
  assign S_AXI_RDATA   = (rvalid && r_ok) ? mem[r_addr[LSB +: IDX_W]] : '0;
  assign S_AXI_RRESP   = !rvalid ? RESP_OKAY : (!r_ok ? RESP_DECERR : (r_slverr ? RESP_SLVERR : RESP_OKAY));
  assign S_AXI_RLAST   = rvalid && (r_cnt == r_len);
  assign S_AXI_RID     = r_id;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BID     = bid;
  assign S_AXI_BRESP   = bresp;
endmodule

// File: tb/tb_axi_mem_slave.sv
// tb/tb_axi_mem_slave.sv - self-checking bench for axi_mem_slave
// Vector table of write/readback bursts, scoreboard queues, plus concurrency and reset sequences.
module tb_axi_mem_slave;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] S_AXI_AWADDR, S_AXI_ARADDR;
  logic [3:0]  S_AXI_AWID, S_AXI_ARID, S_AXI_BID, S_AXI_RID;
  logic [7:0]  S_AXI_AWLEN, S_AXI_ARLEN, S_AXI_WSTRB;
  logic [2:0]  S_AXI_AWSIZE, S_AXI_ARSIZE;
  logic [1:0]  S_AXI_AWBURST, S_AXI_ARBURST, S_AXI_BRESP, S_AXI_RRESP;
  logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
  logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic        S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;
  logic [63:0] S_AXI_WDATA, S_AXI_RDATA;

  axi_mem_slave #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWLEN(S_AXI_AWLEN),
    .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WLAST(S_AXI_WLAST), .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARID(S_AXI_ARID),
    .S_AXI_ARLEN(S_AXI_ARLEN), .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA),
    .S_AXI_RID(S_AXI_RID), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RLAST(S_AXI_RLAST),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { logic [63:0] data; logic [1:0] resp; logic last; } rbeat_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;
  typedef struct {
    logic [31:0] addr; logic [3:0] id; logic [7:0] len; logic [1:0] burst; logic [2:0] size;
    logic [63:0] data; logic [7:0] strb; int bad_last; logic [1:0] exp_b; logic readback; logic toggle;
  } vec_t;

  rbeat_t      r_q[$];
  bexp_t       b_q[$];
  logic [63:0] model [DEPTH];
  vec_t        vt [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no handshake within budget expected handshake", name);
  endtask

  function automatic logic in_rng(input logic [31:0] a);
    return a < 32'(DEPTH * 8);
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] burst);
    return (burst == 2'b00) ? a : a + 32'd8;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size, input logic [63:0] data0,
                           input logic [7:0] strb, input int bad_last, input logic [1:0] exp_resp,
                           input string name);
    logic [31:0] a;
    logic [63:0] d;
    bexp_t       e;
    int          n;
    e.id = id;
    e.resp = exp_resp;
    b_q.push_back(e);
    @(negedge clk);
    S_AXI_AWADDR = addr; S_AXI_AWID = id; S_AXI_AWLEN = len;
    S_AXI_AWBURST = burst; S_AXI_AWSIZE = size; S_AXI_AWVALID = 1'b1;
    n = 0;
    while (!S_AXI_AWREADY && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) timeout_fail({name, " aw"});
    @(negedge clk);
    S_AXI_AWVALID = 1'b0;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      d = data0 + 64'(i);
      S_AXI_WDATA = d; S_AXI_WSTRB = strb;
      S_AXI_WLAST = (i == int'(len)) != (i == bad_last);
      S_AXI_WVALID = 1'b1;
      n = 0;
      while (!S_AXI_WREADY && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) timeout_fail({name, " w"});
      if (in_rng(a))
        for (int b = 0; b < 8; b++)
          if (strb[b]) model[a[12:3]][8*b +: 8] = d[8*b +: 8];
      a = next_addr(a, burst);
      @(negedge clk);
    end
    S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
    S_AXI_BREADY = 1'b1;
    n = 0;
    while (!S_AXI_BVALID && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) timeout_fail({name, " b"});
    else begin
      e = b_q.pop_front();
      check({name, " bid"}, 64'(S_AXI_BID), 64'(e.id));
      check({name, " bresp"}, 64'(S_AXI_BRESP), 64'(e.resp));
    end
    @(negedge clk);
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input logic toggle, input string name);
    logic [31:0] a;
    rbeat_t      e;
    logic [63:0] sd;
    logic [1:0]  sr;
    logic        sl, stalled;
    int          n, beat, t;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      e.data = in_rng(a) ? model[a[12:3]] : 64'd0;
      e.resp = in_rng(a) ? 2'b00 : 2'b11;
      e.last = (i == int'(len));
      r_q.push_back(e);
      a = next_addr(a, burst);
    end
    @(negedge clk);
    S_AXI_ARADDR = addr; S_AXI_ARID = id; S_AXI_ARLEN = len;
    S_AXI_ARBURST = burst; S_AXI_ARSIZE = 3'd3; S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!S_AXI_ARREADY && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) timeout_fail({name, " ar"});
    @(negedge clk);
    S_AXI_ARVALID = 1'b0;
    beat = 0; t = 0; n = 0; stalled = 1'b0; sd = '0; sr = '0; sl = 1'b0;
    while (beat <= int'(len) && n < 400) begin
      S_AXI_RREADY = !toggle || (t % 2 == 0);
      if (stalled) begin
        check({name, " stall rvalid"}, 64'(S_AXI_RVALID), 64'd1);
        check({name, " stall rdata"}, S_AXI_RDATA, sd);
        check({name, " stall rresp"}, 64'(S_AXI_RRESP), 64'(sr));
        check({name, " stall rlast"}, 64'(S_AXI_RLAST), 64'(sl));
        stalled = 1'b0;
      end
      if (S_AXI_RVALID) begin
        if (S_AXI_RREADY) begin
          e = r_q.pop_front();
          check($sformatf("%s rdata[%0d]", name, beat), S_AXI_RDATA, e.data);
          check($sformatf("%s rresp[%0d]", name, beat), 64'(S_AXI_RRESP), 64'(e.resp));
          check($sformatf("%s rlast[%0d]", name, beat), 64'(S_AXI_RLAST), 64'(e.last));
          check($sformatf("%s rid[%0d]", name, beat), 64'(S_AXI_RID), 64'(id));
          beat++;
        end else begin
          stalled = 1'b1;
          sd = S_AXI_RDATA; sr = S_AXI_RRESP; sl = S_AXI_RLAST;
        end
        t++;
      end
      @(negedge clk);
      n++;
    end
    S_AXI_RREADY = 1'b0;
    if (n >= 400) timeout_fail({name, " r"});
    else check({name, " rvalid drop"}, 64'(S_AXI_RVALID), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{32'h100,  4'h3, 8'd0, 2'b01, 3'd3, 64'hDEADBEEF_CAFEF00D, 8'hFF, -1, 2'b00, 1'b1, 1'b0};
    vt[1]  = '{32'h200,  4'h5, 8'd3, 2'b01, 3'd3, 64'd1,                 8'hFF, -1, 2'b00, 1'b1, 1'b1};
    vt[2]  = '{32'h40,   4'h1, 8'd0, 2'b01, 3'd3, 64'd0,                 8'hFF, -1, 2'b00, 1'b0, 1'b0};
    vt[3]  = '{32'h40,   4'h2, 8'd0, 2'b01, 3'd3, 64'hFFFFFFFF_FFFFFFFF, 8'h0F, -1, 2'b00, 1'b1, 1'b0};
    vt[4]  = '{32'h2000, 4'h7, 8'd0, 2'b01, 3'd3, 64'h55,                8'hFF, -1, 2'b11, 1'b1, 1'b0};
    vt[5]  = '{32'h500,  4'h4, 8'd2, 2'b00, 3'd3, 64'h10,                8'hFF, -1, 2'b00, 1'b1, 1'b1};
    vt[6]  = '{32'h1FF8, 4'h6, 8'd1, 2'b01, 3'd3, 64'hA0,                8'hFF, -1, 2'b11, 1'b1, 1'b0};
    vt[7]  = '{32'h600,  4'h8, 8'd1, 2'b01, 3'd3, 64'h30,                8'hFF,  0, 2'b10, 1'b0, 1'b0};
    vt[8]  = '{32'h700,  4'h9, 8'd0, 2'b11, 3'd3, 64'h70,                8'hFF, -1, 2'b10, 1'b0, 1'b0};
    vt[9]  = '{32'h800,  4'hA, 8'd0, 2'b01, 3'd2, 64'h80,                8'hFF, -1, 2'b10, 1'b0, 1'b0};
    vt[10] = '{32'h308,  4'hB, 8'd0, 2'b01, 3'd3, 64'h30830830_83083083, 8'hFF, -1, 2'b00, 1'b1, 1'b0};
    vt[11] = '{32'h2000, 4'hC, 8'd1, 2'b01, 3'd3, 64'h90,                8'hFF,  0, 2'b11, 1'b0, 1'b0};

    rst_n = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWID = '0; S_AXI_AWLEN = '0; S_AXI_AWSIZE = 3'd3; S_AXI_AWBURST = 2'b01;
    S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0; S_AXI_ARADDR = '0; S_AXI_ARID = '0; S_AXI_ARLEN = '0; S_AXI_ARSIZE = 3'd3;
    S_AXI_ARBURST = 2'b01; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    repeat (3) @(negedge clk);
    check("reset awready", 64'(S_AXI_AWREADY), 64'd0);
    check("reset arready", 64'(S_AXI_ARREADY), 64'd0);
    check("reset bvalid", 64'(S_AXI_BVALID), 64'd0);
    check("reset rvalid", 64'(S_AXI_RVALID), 64'd0);
    check("reset rdata", S_AXI_RDATA, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset awready", 64'(S_AXI_AWREADY), 64'd1);
    check("post-reset arready", 64'(S_AXI_ARREADY), 64'd1);

    for (int v = 0; v < 12; v++) begin
      axi_write(vt[v].addr, vt[v].id, vt[v].len, vt[v].burst, vt[v].size, vt[v].data, vt[v].strb,
                vt[v].bad_last, vt[v].exp_b, $sformatf("vec%0d wr", v));
      if (vt[v].readback)
        axi_read(vt[v].addr, vt[v].id, vt[v].len, (vt[v].burst == 2'b00) ? 2'b00 : 2'b01,
                 vt[v].toggle, $sformatf("vec%0d rd", v));
    end

    fork
      axi_write(32'h300, 4'h1, 8'd0, 2'b01, 3'd3, 64'h00000300_00000300, 8'hFF, -1, 2'b00, "conc wr");
      axi_read(32'h308, 4'h2, 8'd0, 2'b01, 1'b0, "conc rd");
    join
    axi_read(32'h300, 4'h3, 8'd0, 2'b01, 1'b0, "conc rdback");

    @(negedge clk);
    S_AXI_ARADDR = 32'h200; S_AXI_ARID = 4'h5; S_AXI_ARLEN = 8'd3;
    S_AXI_ARBURST = 2'b01; S_AXI_ARSIZE = 3'd3; S_AXI_ARVALID = 1'b1;
    begin
      int n = 0;
      while (!S_AXI_ARREADY && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) timeout_fail("rst ar");
    end
    @(negedge clk);
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b1;
    check("rst beat0 rvalid", 64'(S_AXI_RVALID), 64'd1);
    check("rst beat0 rdata", S_AXI_RDATA, model[32'h200 >> 3]);
    @(negedge clk);
    rst_n = 1'b0;
    S_AXI_RREADY = 1'b0;
    @(negedge clk);
    check("mid-burst reset rvalid", 64'(S_AXI_RVALID), 64'd0);
    check("mid-burst reset rdata", S_AXI_RDATA, 64'd0);
    check("mid-burst reset rid", 64'(S_AXI_RID), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("release arready", 64'(S_AXI_ARREADY), 64'd1);
    check("release awready", 64'(S_AXI_AWREADY), 64'd1);
    axi_read(32'h200, 4'h5, 8'd3, 2'b01, 1'b0, "retained");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
